// File: rtl/plic_gateway_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : plic_gateway_ctrl
// Description : Platform-level interrupt controller with level/edge gateways,
//               priorities, per-target enables/thresholds and claim/complete.
// Revision    : 1.0 - initial release
// ============================================================================

module plic_gateway_ctrl #(
  parameter int                    SOURCE_NUM   = 31,
  parameter int                    TARGET_NUM   = 2,
  parameter int                    PRIO_WIDTH   = 3,
  parameter logic [SOURCE_NUM-1:0] EDGE_TRIGGER = '0,
  parameter int                    ADDR_WIDTH   = 16,
  parameter int                    IDW          = $clog2(SOURCE_NUM + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [SOURCE_NUM-1:0]          intr_src_i,
  input  logic                           reg_valid_i,
  input  logic                           reg_write_i,
  input  logic [ADDR_WIDTH-1:0]          reg_addr_i,
  input  logic [31:0]                    reg_wdata_i,
  input  logic [3:0]                     reg_wstrb_i,
  output logic                           reg_ready_o,
  output logic [31:0]                    reg_rdata_o,
  output logic                           reg_error_o,
  output logic [TARGET_NUM-1:0]          irq_o,
  output logic [TARGET_NUM*IDW-1:0]      irq_id_o
);

  localparam int NWORDS = (SOURCE_NUM + 32) / 32;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    error_q, error_d;
  logic [PRIO_WIDTH-1:0]   prio_q [1:SOURCE_NUM];
  logic [PRIO_WIDTH-1:0]   prio_d [1:SOURCE_NUM];
  logic [SOURCE_NUM:1]     pending_q, pending_d;
  logic [SOURCE_NUM:1]     in_service_q, in_service_d;
  logic [SOURCE_NUM:1]     edge_hold_q, edge_hold_d;
  logic [SOURCE_NUM-1:0]   prev_src_q, prev_src_d;
  logic [SOURCE_NUM:1]     enable_q [TARGET_NUM];
  logic [SOURCE_NUM:1]     enable_d [TARGET_NUM];
  logic [PRIO_WIDTH-1:0]   thr_q [TARGET_NUM];
  logic [PRIO_WIDTH-1:0]   thr_d [TARGET_NUM];
  logic [TARGET_NUM-1:0]   irq_q, irq_d;
  logic [TARGET_NUM*IDW-1:0] irq_id_q, irq_id_d;

  logic [IDW-1:0]          best_id   [TARGET_NUM];
  logic [PRIO_WIDTH-1:0]   best_prio [TARGET_NUM];

  logic [31:0] addr_w, region_w, word_w, et_w, ew_w, ct_w, coff_w;
  logic        strb_ok_w, bus_go_w;
  logic        dec_err, prio_wr, en_wr, thr_wr, claim, complete;
  logic [31:0] dec_rdata;

  assign addr_w    = 32'(reg_addr_i);
  assign region_w  = addr_w >> 12;
  assign word_w    = (addr_w >> 2) & 32'h0000_03FF;
  assign et_w      = (addr_w - 32'h0000_2000) >> 7;
  assign ew_w      = (addr_w >> 2) & 32'h0000_001F;
  assign ct_w      = (addr_w >> 4) & 32'h0000_00FF;
  assign coff_w    = addr_w & 32'h0000_000F;
  assign strb_ok_w = (reg_wstrb_i == 4'hF);

  // Strict '>' keeps the lowest ID on ties and excludes priority 0.
  always_comb begin
    for (int t = 0; t < TARGET_NUM; t++) begin
      best_id[t]   = '0;
      best_prio[t] = '0;
      for (int id = 1; id <= SOURCE_NUM; id++) begin
        if (pending_q[id] && enable_q[t][id] && (prio_q[id] > best_prio[t])) begin
          best_prio[t] = prio_q[id];
          best_id[t]   = IDW'(id);
        end
      end
    end
  end

  always_comb begin
    dec_err   = 1'b0;
    dec_rdata = '0;
    prio_wr   = 1'b0;
    en_wr     = 1'b0;
    thr_wr    = 1'b0;
    claim     = 1'b0;
    complete  = 1'b0;
    if (addr_w[1:0] != 2'b00) begin
      dec_err = 1'b1;
    end else if (region_w == 32'd0) begin
      if (word_w > SOURCE_NUM) begin
        dec_err = 1'b1;
      end else if (reg_write_i) begin
        if (word_w == 32'd0 || !strb_ok_w) dec_err = 1'b1;
        else                               prio_wr = 1'b1;
      end else begin
        for (int id = 1; id <= SOURCE_NUM; id++)
          if (word_w == id) dec_rdata = 32'(prio_q[id]);
      end
    end else if (region_w == 32'd1) begin
      if (word_w >= NWORDS || reg_write_i) begin
        dec_err = 1'b1;
      end else begin
        for (int id = 1; id <= SOURCE_NUM; id++)
          if ((id >> 5) == word_w) dec_rdata = dec_rdata | (32'(pending_q[id]) << (id % 32));
      end
    end else if (region_w == 32'd2 || region_w == 32'd3) begin
      if (et_w >= TARGET_NUM || ew_w >= NWORDS) begin
        dec_err = 1'b1;
      end else if (reg_write_i) begin
        if (!strb_ok_w) dec_err = 1'b1;
        else            en_wr   = 1'b1;
      end else begin
        for (int t = 0; t < TARGET_NUM; t++)
          for (int id = 1; id <= SOURCE_NUM; id++)
            if (et_w == t && (id >> 5) == ew_w)
              dec_rdata = dec_rdata | (32'(enable_q[t][id]) << (id % 32));
      end
    end else if (region_w == 32'd4) begin
      if (ct_w >= TARGET_NUM || (coff_w != 32'd0 && coff_w != 32'd4)) begin
        dec_err = 1'b1;
      end else if (reg_write_i) begin
        if (!strb_ok_w)            dec_err  = 1'b1;
        else if (coff_w == 32'd0)  thr_wr   = 1'b1;
        else                       complete = 1'b1;
      end else begin
        claim = (coff_w == 32'd4);
        for (int t = 0; t < TARGET_NUM; t++)
          if (ct_w == t) dec_rdata = (coff_w == 32'd0) ? 32'(thr_q[t]) : 32'(best_id[t]);
      end
    end else begin
      dec_err = 1'b1;
    end
  end

  assign bus_go_w = (state_q == S_IDLE) && reg_valid_i && !dec_err;

  always_comb begin
    state_d      = state_q;
    rdata_d      = rdata_q;
    error_d      = error_q;
    prio_d       = prio_q;
    pending_d    = pending_q;
    in_service_d = in_service_q;
    edge_hold_d  = edge_hold_q;
    prev_src_d   = intr_src_i;
    enable_d     = enable_q;
    thr_d        = thr_q;
    irq_d        = '0;
    irq_id_d     = '0;

    case (state_q)
      S_IDLE: if (reg_valid_i) begin
        state_d = S_RESP;
        rdata_d = dec_err ? 32'd0 : dec_rdata;
        error_d = dec_err;
      end
      default: state_d = S_IDLE;
    endcase

    // Gateways see only registered state; bus side effects below override them.
    for (int id = 1; id <= SOURCE_NUM; id++) begin
      if (EDGE_TRIGGER[id-1]) begin
        if (!pending_q[id] && !in_service_q[id] &&
            ((intr_src_i[id-1] && !prev_src_q[id-1]) || edge_hold_q[id])) begin
          pending_d[id]   = 1'b1;
          edge_hold_d[id] = 1'b0;
        end else if (intr_src_i[id-1] && !prev_src_q[id-1]) begin
          edge_hold_d[id] = 1'b1;
        end
      end else if (intr_src_i[id-1] && !pending_q[id] && !in_service_q[id]) begin
        pending_d[id] = 1'b1;
      end
    end

    if (bus_go_w) begin
      for (int id = 1; id <= SOURCE_NUM; id++)
        if (prio_wr && word_w == id) prio_d[id] = reg_wdata_i[PRIO_WIDTH-1:0];
      for (int t = 0; t < TARGET_NUM; t++) begin
        for (int id = 1; id <= SOURCE_NUM; id++)
          if (en_wr && et_w == t && (id >> 5) == ew_w)
            enable_d[t][id] = |(reg_wdata_i & (32'd1 << (id % 32)));
        if (thr_wr && ct_w == t) thr_d[t] = reg_wdata_i[PRIO_WIDTH-1:0];
        for (int id = 1; id <= SOURCE_NUM; id++) begin
          if (claim && ct_w == t && best_id[t] == IDW'(id)) begin
            pending_d[id]    = 1'b0;
            in_service_d[id] = 1'b1;
          end
          if (complete && ct_w == t && reg_wdata_i == 32'(id) &&
              in_service_q[id] && enable_q[t][id])
            in_service_d[id] = 1'b0;
        end
      end
    end

    for (int t = 0; t < TARGET_NUM; t++) begin
      irq_d[t]                = best_prio[t] > thr_q[t];
      irq_id_d[t*IDW +: IDW]  = best_id[t];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      rdata_q      <= '0;
      error_q      <= 1'b0;
      pending_q    <= '0;
      in_service_q <= '0;
      edge_hold_q  <= '0;
      prev_src_q   <= '0;
      irq_q        <= '0;
      irq_id_q     <= '0;
      for (int id = 1; id <= SOURCE_NUM; id++) prio_q[id] <= '0;
      for (int t = 0; t < TARGET_NUM; t++) begin
        enable_q[t] <= '0;
        thr_q[t]    <= '0;
      end
    end else begin
      state_q      <= state_d;
      rdata_q      <= rdata_d;
      error_q      <= error_d;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      edge_hold_q  <= edge_hold_d;
      prev_src_q   <= prev_src_d;
      irq_q        <= irq_d;
      irq_id_q     <= irq_id_d;
      prio_q       <= prio_d;
      enable_q     <= enable_d;
      thr_q        <= thr_d;
    end
  end

  assign reg_ready_o = (state_q == S_RESP);
  assign reg_rdata_o = rdata_q;
  assign reg_error_o = error_q;
  assign irq_o       = irq_q;
  assign irq_id_o    = irq_id_q;

endmodule

`default_nettype wire

// File: tb/tb_plic_gateway_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_plic_gateway_ctrl
// Description : Directed self-checking bench for plic_gateway_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_plic_gateway_ctrl;

  logic        clk;
  logic        rst;
  logic [30:0] src;
  logic        valid;
  logic        write;
  logic [15:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready;
  logic [31:0] rdata;
  logic        err;
  logic [1:0]  irq;
  logic [9:0]  irq_id;

  int n_cmp;
  int n_fail;

  plic_gateway_ctrl #(
    .SOURCE_NUM   (31),
    .TARGET_NUM   (2),
    .PRIO_WIDTH   (3),
    .EDGE_TRIGGER (31'h0000_0008),
    .ADDR_WIDTH   (16)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .intr_src_i  (src),
    .reg_valid_i (valid),
    .reg_write_i (write),
    .reg_addr_i  (addr),
    .reg_wdata_i (wdata),
    .reg_wstrb_i (wstrb),
    .reg_ready_o (ready),
    .reg_rdata_o (rdata),
    .reg_error_o (err),
    .irq_o       (irq),
    .irq_id_o    (irq_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic wr, input logic [15:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rd, output logic er,
                     output int cyc);
    @(negedge clk);
    valid = 1'b1; write = wr; addr = a; wdata = d; wstrb = s;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!ready && cyc < 8);
    chk("ready_seen", 32'(ready), 32'd1);
    rd = rdata;
    er = err;
    valid = 1'b0; write = 1'b0;
    @(negedge clk);
    chk("ready_drop", 32'(ready), 32'd0);
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] a, input logic [31:0] exp);
    logic [31:0] r;
    logic        e;
    int          c;
    bus(1'b0, a, 32'd0, 4'hF, r, e, c);
    chk(tag, r, exp);
    chk("rd_err", 32'(e), 32'd0);
  endtask

  task automatic wr_ok(input logic [15:0] a, input logic [31:0] d);
    logic [31:0] r;
    logic        e;
    int          c;
    bus(1'b1, a, d, 4'hF, r, e, c);
    chk("wr_err", 32'(e), 32'd0);
  endtask

  initial begin
    logic [31:0] r;
    logic        e;
    int          c;
    n_cmp = 0; n_fail = 0;
    rst = 1'b1; src = '0; valid = 1'b0; write = 1'b0;
    addr = '0; wdata = '0; wstrb = 4'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_irq_id", 32'(irq_id), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    rd_chk("rst_prio3", 16'h000C, 32'd0);
    rd_chk("rst_pend0", 16'h1000, 32'd0);

    // Level source 5
    wr_ok(16'h0014, 32'd3);
    wr_ok(16'h2000, 32'h0000_0020);
    wr_ok(16'h4000, 32'd1);
    src[4] = 1'b1;
    @(negedge clk);
    chk("lvl_irq_n1", 32'(irq[0]), 32'd0);
    @(negedge clk);
    chk("lvl_irq_n2", 32'(irq[0]), 32'd1);
    chk("lvl_id", 32'(irq_id[4:0]), 32'd5);
    rd_chk("lvl_claim", 16'h4004, 32'd5);
    chk("lvl_irq_claimed", 32'(irq[0]), 32'd0);
    rd_chk("lvl_pend_insvc", 16'h1000, 32'd0);
    wr_ok(16'h4004, 32'd5);
    @(negedge clk);
    chk("lvl_repend_irq", 32'(irq[0]), 32'd1);
    chk("lvl_repend_id", 32'(irq_id[4:0]), 32'd5);
    src[4] = 1'b0;
    rd_chk("lvl_claim2", 16'h4004, 32'd5);
    wr_ok(16'h4004, 32'd5);
    repeat (2) @(negedge clk);
    rd_chk("lvl_pend_clean", 16'h1000, 32'd0);
    chk("lvl_irq_clean", 32'(irq[0]), 32'd0);

    // Priority and tie-break: 7 (prio 6), then 2 and 9 (prio 4)
    wr_ok(16'h0008, 32'd4);
    wr_ok(16'h0024, 32'd4);
    wr_ok(16'h001C, 32'd6);
    wr_ok(16'h2000, 32'h0000_0284);
    src = 31'h0000_0142;
    @(negedge clk);
    src = '0;
    repeat (2) @(negedge clk);
    rd_chk("tie_pend", 16'h1000, 32'h0000_0284);
    chk("tie_irq_id", 32'(irq_id[4:0]), 32'd7);
    rd_chk("tie_claim_a", 16'h4004, 32'd7);
    rd_chk("tie_claim_b", 16'h4004, 32'd2);
    rd_chk("tie_claim_c", 16'h4004, 32'd9);
    rd_chk("tie_claim_none", 16'h4004, 32'd0);
    chk("tie_irq_after", 32'(irq[0]), 32'd0);
    wr_ok(16'h4004, 32'd7);
    wr_ok(16'h4004, 32'd2);
    wr_ok(16'h4004, 32'd9);
    wr_ok(16'h4004, 32'd0);
    rd_chk("tie_pend_after", 16'h1000, 32'd0);

    // Edge source 4: one held edge survives, extra edges dropped
    wr_ok(16'h0010, 32'd5);
    wr_ok(16'h2000, 32'h0000_0010);
    src[3] = 1'b1;
    @(negedge clk);
    src[3] = 1'b0;
    @(negedge clk);
    chk("edge_irq", 32'(irq[0]), 32'd1);
    chk("edge_id", 32'(irq_id[4:0]), 32'd4);
    rd_chk("edge_claim", 16'h4004, 32'd4);
    for (int k = 0; k < 2; k++) begin
      src[3] = 1'b1;
      @(negedge clk);
      src[3] = 1'b0;
      @(negedge clk);
    end
    rd_chk("edge_pend_held", 16'h1000, 32'd0);
    wr_ok(16'h4004, 32'd4);
    rd_chk("edge_pend_release", 16'h1000, 32'h0000_0010);
    rd_chk("edge_claim2", 16'h4004, 32'd4);
    wr_ok(16'h4004, 32'd4);
    repeat (3) @(negedge clk);
    rd_chk("edge_pend_final", 16'h1000, 32'd0);
    chk("edge_irq_final", 32'(irq[0]), 32'd0);

    // Threshold and second target
    wr_ok(16'h0018, 32'd2);
    wr_ok(16'h2000, 32'h0000_0040);
    wr_ok(16'h2080, 32'h0000_0040);
    wr_ok(16'h4000, 32'd2);
    wr_ok(16'h4010, 32'd1);
    rd_chk("thr1_read", 16'h4010, 32'd1);
    rd_chk("en1_read", 16'h2080, 32'h0000_0040);
    src[5] = 1'b1;
    @(negedge clk);
    src[5] = 1'b0;
    @(negedge clk);
    chk("tgt_irq", 32'(irq), 32'd2);
    chk("tgt_irq_id", 32'(irq_id), 32'h0000_00C6);
    rd_chk("tgt1_claim", 16'h4014, 32'd6);
    chk("tgt_irq_after", 32'(irq), 32'd0);
    wr_ok(16'h4014, 32'd6);

    // Bus errors and field widths
    bus(1'b0, 16'h3000, 32'd0, 4'hF, r, e, c);
    chk("err_unmapped", 32'(e), 32'd1);
    chk("err_unmapped_rdata", r, 32'd0);
    chk("err_unmapped_lat", 32'(c), 32'd1);
    bus(1'b1, 16'h1000, 32'hFFFF_FFFF, 4'hF, r, e, c);
    chk("err_ro_pend", 32'(e), 32'd1);
    chk("err_ro_pend_lat", 32'(c), 32'd1);
    bus(1'b1, 16'h000C, 32'd7, 4'h1, r, e, c);
    chk("err_wstrb", 32'(e), 32'd1);
    chk("err_wstrb_lat", 32'(c), 32'd1);
    rd_chk("err_wstrb_prio", 16'h000C, 32'd0);
    bus(1'b1, 16'h0000, 32'd3, 4'hF, r, e, c);
    chk("err_prio0_wr", 32'(e), 32'd1);
    wr_ok(16'h000C, 32'hFFFF_FFFF);
    rd_chk("prio_width", 16'h000C, 32'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
